// File: rtl/hamming_encoder_tx.sv
// hamming_encoder_tx: Hamming [7,4] encoder with a one-nibble holding register
// and an MSB-first serial transmitter with frame strobes.
// Optional feature macro: HAMMING_OVERALL_PARITY_EN appends an overall parity
// bit after c[0] (8-bit frames, SECDED at the receiver).
module hamming_encoder_tx #(
   parameter int unsigned BIT_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] data_in,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       tx_bit,
   output logic       tx_valid,
   output logic       tx_first,
   output logic       tx_last,
   output logic [6:0] codeword,
   output logic       busy
);

`ifdef HAMMING_OVERALL_PARITY_EN
   localparam int unsigned FRAME_LEN = 8;
`else
   localparam int unsigned FRAME_LEN = 7;
`endif
   localparam int unsigned DATA_W = 4;
   localparam int unsigned CW_W   = 7;
   localparam int unsigned BIT_W  = 3;
   localparam int unsigned CYC_W  = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Team bit layout: data in c[6:3], parity in c[2:0]
   function automatic logic [CW_W-1:0] encode(input logic [DATA_W-1:0] d);
      return {d[3], d[2], d[1], d[0],
              d[2] ^ d[1] ^ d[0],
              d[3] ^ d[1] ^ d[0],
              d[3] ^ d[2] ^ d[0]};
   endfunction

   // Serial frame image, MSB transmitted first
   function automatic logic [FRAME_LEN-1:0] frame_of(input logic [CW_W-1:0] cw);
`ifdef HAMMING_OVERALL_PARITY_EN
      return {cw, ^cw};
`else
      return cw;
`endif
   endfunction

   state_t               state_q,    state_d;
   logic [DATA_W-1:0]    hold_q,     hold_d;
   logic                 hold_full_q, hold_full_d;
   logic                 in_ready_q, in_ready_d;
   logic [FRAME_LEN-1:0] shreg_q,    shreg_d;
   logic [CYC_W-1:0]     cyc_cnt_q,  cyc_cnt_d;
   logic [BIT_W-1:0]     bit_cnt_q,  bit_cnt_d;
   logic [CW_W-1:0]      codeword_q, codeword_d;
   logic                 tx_bit_q,   tx_bit_d;
   logic                 tx_valid_q, tx_valid_d;
   logic                 tx_first_q, tx_first_d;
   logic                 tx_last_q,  tx_last_d;
   logic                 busy_q,     busy_d;

   // Next-state: handshake, frame sequencing and registered output values
   always_comb begin
      logic transfer;
      logic load;
      logic last_cyc;
      logic last_bit;

      state_d     = state_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      shreg_d     = shreg_q;
      cyc_cnt_d   = cyc_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      codeword_d  = codeword_q;
      load        = 1'b0;

      transfer = in_valid && in_ready_q;
      last_cyc = (cyc_cnt_q == CYC_W'(BIT_CYCLES - 1));
      last_bit = (bit_cnt_q == BIT_W'(FRAME_LEN - 1));

      case (state_q)
         IDLE: begin
            if (hold_full_q) load = 1'b1;
         end
         SHIFT: begin
            if (last_cyc) begin
               cyc_cnt_d = '0;
               if (last_bit) begin
                  if (hold_full_q) begin
                     load = 1'b1;
                  end else begin
                     state_d   = IDLE;
                     bit_cnt_d = '0;
                  end
               end else begin
                  shreg_d   = {shreg_q[FRAME_LEN-2:0], 1'b0};
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end else begin
               cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Consuming the buffered nibble starts a new frame (also back-to-back)
      if (load) begin
         codeword_d  = encode(hold_q);
         shreg_d     = frame_of(encode(hold_q));
         hold_full_d = 1'b0;
         state_d     = SHIFT;
         cyc_cnt_d   = '0;
         bit_cnt_d   = '0;
      end

      // Transfer and load are exclusive: in_ready implies the buffer is empty
      if (transfer) begin
         hold_d      = data_in;
         hold_full_d = 1'b1;
      end

      in_ready_d = ~hold_full_d;
      tx_valid_d = (state_d == SHIFT);
      tx_bit_d   = tx_valid_d && shreg_d[FRAME_LEN-1];
      tx_first_d = tx_valid_d && (bit_cnt_d == '0);
      tx_last_d  = tx_valid_d && (bit_cnt_d == BIT_W'(FRAME_LEN - 1));
      busy_d     = tx_valid_d || hold_full_d;
   end

   // State and output registers; reset aborts any frame and empties the buffer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         in_ready_q  <= 1'b0;
         shreg_q     <= '0;
         cyc_cnt_q   <= '0;
         bit_cnt_q   <= '0;
         codeword_q  <= '0;
         tx_bit_q    <= 1'b0;
         tx_valid_q  <= 1'b0;
         tx_first_q  <= 1'b0;
         tx_last_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         in_ready_q  <= in_ready_d;
         shreg_q     <= shreg_d;
         cyc_cnt_q   <= cyc_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         codeword_q  <= codeword_d;
         tx_bit_q    <= tx_bit_d;
         tx_valid_q  <= tx_valid_d;
         tx_first_q  <= tx_first_d;
         tx_last_q   <= tx_last_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready = in_ready_q;
   assign tx_bit   = tx_bit_q;
   assign tx_valid = tx_valid_q;
   assign tx_first = tx_first_q;
   assign tx_last  = tx_last_q;
   assign codeword = codeword_q;
   assign busy     = busy_q;

endmodule
